// File: rtl/int_accept_unit.sv
// Interrupt/trap acceptance: arbitrates PIC, NMI, timer and ECALL/EBREAK at
// instruction boundaries, redirects fetch to VEC_BASE + cause*4 and handles MRET.
module int_accept_unit #(
  parameter logic [31:0] VEC_BASE = 32'h0000_0100
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        en_inter_i,
  input  logic        en_int_i,
  input  logic        en_tmr_i,
  input  logic        en_nmi_i,
  input  logic        en_ecall_i,
  input  logic        en_ebreak_i,
  input  logic        int_i,
  input  logic [2:0]  int_num_i,
  input  logic        nmi_i,
  input  logic [31:0] limit_i,
  input  logic        ecall_i,
  input  logic        ebreak_i,
  input  logic        mret_i,
  input  logic        commit_valid_i,
  input  logic [31:0] pc_i,
  output logic        trap_o,
  output logic [31:0] trap_pc_o,
  output logic [31:0] epc_o,
  output logic [3:0]  cause_o,
  output logic        int_ack_o,
  output logic        in_handler_o,
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HANDLER = 2'd1,
    S_NMI     = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        prior_hnd_q, prior_hnd_d;
  logic        nmi_prev_q, nmi_pend_q, nmi_pend_d;
  logic        tmr_pend_q, tmr_pend_d;
  logic [31:0] count_q, count_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] nmi_epc_q, nmi_epc_d;
  logic [31:0] trap_pc_q, trap_pc_d;
  logic [3:0]  cause_q, cause_d;
  logic        trap_q, trap_d;
  logic        ack_q, ack_d;
  logic        take_nmi, take_tmr;
  logic        nmi_edge, tmr_match;
  logic        nmi_req, ext_req, tmr_req;

  function automatic logic [31:0] vector_of(input logic [3:0] c);
    return VEC_BASE + {26'd0, c, 2'b00};
  endfunction

  assign nmi_edge  = nmi_i & ~nmi_prev_q;
  assign tmr_match = en_tmr_i && (limit_i != 32'd0) && (count_q == limit_i);
  assign nmi_req   = nmi_pend_q & en_nmi_i;
  assign ext_req   = int_i & en_int_i & en_inter_i;
  assign tmr_req   = tmr_pend_q & en_tmr_i & en_inter_i;

  always_comb begin
    state_d     = state_q;
    prior_hnd_d = prior_hnd_q;
    epc_d       = epc_q;
    nmi_epc_d   = nmi_epc_q;
    cause_d     = cause_q;
    trap_pc_d   = trap_pc_q;
    trap_d      = 1'b0;
    ack_d       = 1'b0;
    take_nmi    = 1'b0;
    take_tmr    = 1'b0;
    if (commit_valid_i) begin
      unique case (state_q)
        S_IDLE: begin
          // mret has no meaning here and simply falls through to the sources
          if (nmi_req) begin
            trap_d      = 1'b1;
            cause_d     = 4'd11;
            trap_pc_d   = vector_of(4'd11);
            nmi_epc_d   = pc_i;
            prior_hnd_d = 1'b0;
            take_nmi    = 1'b1;
            state_d     = S_NMI;
          end else if (ext_req) begin
            trap_d    = 1'b1;
            ack_d     = 1'b1;
            cause_d   = {1'b0, int_num_i};
            trap_pc_d = vector_of({1'b0, int_num_i});
            epc_d     = pc_i;
            state_d   = S_HANDLER;
          end else if (tmr_req) begin
            trap_d    = 1'b1;
            cause_d   = 4'd8;
            trap_pc_d = vector_of(4'd8);
            epc_d     = pc_i;
            take_tmr  = 1'b1;
            state_d   = S_HANDLER;
          end else if (ecall_i && en_ecall_i) begin
            trap_d    = 1'b1;
            cause_d   = 4'd9;
            trap_pc_d = vector_of(4'd9);
            epc_d     = pc_i + 32'd4;
            state_d   = S_HANDLER;
          end else if (ebreak_i && en_ebreak_i) begin
            trap_d    = 1'b1;
            cause_d   = 4'd10;
            trap_pc_d = vector_of(4'd10);
            epc_d     = pc_i + 32'd4;
            state_d   = S_HANDLER;
          end
        end
        S_HANDLER: begin
          if (mret_i) begin
            trap_d    = 1'b1;
            trap_pc_d = epc_q;
            state_d   = S_IDLE;
          end else if (nmi_req) begin
            trap_d      = 1'b1;
            cause_d     = 4'd11;
            trap_pc_d   = vector_of(4'd11);
            nmi_epc_d   = pc_i;
            prior_hnd_d = 1'b1;
            take_nmi    = 1'b1;
            state_d     = S_NMI;
          end
        end
        S_NMI: begin
          if (mret_i) begin
            trap_d    = 1'b1;
            trap_pc_d = nmi_epc_q;
            state_d   = prior_hnd_q ? S_HANDLER : S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // A new event in the same cycle as a take wins, so it is never lost by the clear.
  always_comb begin
    nmi_pend_d = nmi_edge ? 1'b1 : (take_nmi ? 1'b0 : nmi_pend_q);
    tmr_pend_d = tmr_match ? 1'b1 : (take_tmr ? 1'b0 : tmr_pend_q);
    count_d    = count_q;
    if (en_tmr_i) count_d = tmr_match ? 32'd0 : count_q + 32'd1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      prior_hnd_q <= 1'b0;
      nmi_prev_q  <= 1'b0;
      nmi_pend_q  <= 1'b0;
      tmr_pend_q  <= 1'b0;
      count_q     <= 32'd0;
      epc_q       <= 32'd0;
      nmi_epc_q   <= 32'd0;
      trap_pc_q   <= 32'd0;
      cause_q     <= 4'd0;
      trap_q      <= 1'b0;
      ack_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      prior_hnd_q <= prior_hnd_d;
      nmi_prev_q  <= nmi_i;
      nmi_pend_q  <= nmi_pend_d;
      tmr_pend_q  <= tmr_pend_d;
      count_q     <= count_d;
      epc_q       <= epc_d;
      nmi_epc_q   <= nmi_epc_d;
      trap_pc_q   <= trap_pc_d;
      cause_q     <= cause_d;
      trap_q      <= trap_d;
      ack_q       <= ack_d;
    end
  end

  assign trap_o       = trap_q;
  assign trap_pc_o    = trap_pc_q;
  assign epc_o        = epc_q;
  assign cause_o      = cause_q;
  assign int_ack_o    = ack_q;
  assign in_handler_o = (state_q != S_IDLE);
  assign state_o      = state_q;

endmodule

// File: tb/tb_int_accept_unit.sv
// Scenario bench for int_accept_unit: expected output vectors are queued as each
// cycle is driven and compared against sampled outputs at the end of each scenario.
module tb_int_accept_unit;

  localparam int W = 73;
  localparam logic [1:0] S_IDLE = 2'd0, S_HND = 2'd1, S_NMI = 2'd2;

  logic        clk_i, rst_n_i;
  logic        en_inter_i, en_int_i, en_tmr_i, en_nmi_i, en_ecall_i, en_ebreak_i;
  logic        int_i, nmi_i, ecall_i, ebreak_i, mret_i, commit_valid_i;
  logic [2:0]  int_num_i;
  logic [31:0] limit_i, pc_i;
  logic        trap_o, int_ack_o, in_handler_o;
  logic [31:0] trap_pc_o, epc_o;
  logic [3:0]  cause_o;
  logic [1:0]  state_o;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];
  string        tag_q[$];
  int           passed = 0;
  int           total  = 0;

  int_accept_unit dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .en_inter_i(en_inter_i), .en_int_i(en_int_i), .en_tmr_i(en_tmr_i),
    .en_nmi_i(en_nmi_i), .en_ecall_i(en_ecall_i), .en_ebreak_i(en_ebreak_i),
    .int_i(int_i), .int_num_i(int_num_i), .nmi_i(nmi_i), .limit_i(limit_i),
    .ecall_i(ecall_i), .ebreak_i(ebreak_i), .mret_i(mret_i),
    .commit_valid_i(commit_valid_i), .pc_i(pc_i),
    .trap_o(trap_o), .trap_pc_o(trap_pc_o), .epc_o(epc_o), .cause_o(cause_o),
    .int_ack_o(int_ack_o), .in_handler_o(in_handler_o), .state_o(state_o)
  );

  // clock / reset
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, got running expected done");
    $fatal(1);
  end

  // driver tasks
  task automatic step;
    @(posedge clk_i);
    #1;
  endtask

  task automatic sample;
    obs_q.push_back({trap_o, trap_pc_o, cause_o, int_ack_o, epc_o, in_handler_o, state_o});
  endtask

  task automatic push_exp(input string tag, input logic tr, input logic [31:0] tpc,
                          input logic [3:0] c, input logic ak, input logic [31:0] e,
                          input logic [1:0] st);
    logic inh;
    inh = (st != S_IDLE);
    exp_q.push_back({tr, tpc, c, ak, e, inh, st});
    tag_q.push_back(tag);
  endtask

  task automatic boundary(input logic [31:0] pc);
    commit_valid_i = 1'b1;
    pc_i = pc;
    step();
    sample();
    commit_valid_i = 1'b0;
    mret_i = 1'b0;
    ecall_i = 1'b0;
    ebreak_i = 1'b0;
  endtask

  task automatic do_reset(input logic tmr_en, input logic [31:0] lim);
    rst_n_i = 1'b0;
    int_i = 1'b0; int_num_i = 3'd0; nmi_i = 1'b0;
    ecall_i = 1'b0; ebreak_i = 1'b0; mret_i = 1'b0;
    commit_valid_i = 1'b0; pc_i = 32'd0;
    en_inter_i = 1'b1; en_int_i = 1'b1; en_nmi_i = 1'b1;
    en_ecall_i = 1'b1; en_ebreak_i = 1'b1;
    en_tmr_i = tmr_en; limit_i = lim;
    step();
    step();
    rst_n_i = 1'b1;
  endtask

  // scenarios
  task automatic test_reset;
    logic [W-1:0] e, o; string t;
    do_reset(1'b0, 32'd0);
    push_exp("reset_values", 0, 32'd0, 4'd0, 0, 32'd0, S_IDLE);
    sample();
    push_exp("reset_idle_cycle", 0, 32'd0, 4'd0, 0, 32'd0, S_IDLE);
    step();
    sample();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); t = tag_q.pop_front(); total++;
      if (obs_q.size() == 0) $display("FAIL %s: got no sample, expected %h", t, e);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL %s: got %h expected %h", t, o, e);
        else passed++;
      end
    end
  endtask

  task automatic test_ext_int;
    logic [W-1:0] e, o; string t;
    int_i = 1'b1; int_num_i = 3'd5;
    push_exp("ext_take", 1, 32'h114, 4'd5, 1, 32'h200, S_HND);
    boundary(32'h200);
    int_i = 1'b0;
    push_exp("ext_pulse_end", 0, 32'h114, 4'd5, 0, 32'h200, S_HND);
    step();
    sample();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); t = tag_q.pop_front(); total++;
      if (obs_q.size() == 0) $display("FAIL %s: got no sample, expected %h", t, e);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL %s: got %h expected %h", t, o, e);
        else passed++;
      end
    end
  endtask

  task automatic test_mret_held;
    logic [W-1:0] e, o; string t;
    int_i = 1'b1; int_num_i = 3'd2;
    push_exp("hnd_int_masked", 0, 32'h114, 4'd5, 0, 32'h200, S_HND);
    boundary(32'h210);
    mret_i = 1'b1;
    push_exp("mret_return", 1, 32'h200, 4'd5, 0, 32'h200, S_IDLE);
    boundary(32'h220);
    push_exp("held_int_taken", 1, 32'h108, 4'd2, 1, 32'h230, S_HND);
    boundary(32'h230);
    int_i = 1'b0; mret_i = 1'b1;
    push_exp("mret_return2", 1, 32'h230, 4'd2, 0, 32'h230, S_IDLE);
    boundary(32'h240);
    int_i = 1'b1; int_num_i = 3'd1;
    push_exp("no_boundary", 0, 32'h230, 4'd2, 0, 32'h230, S_IDLE);
    step();
    sample();
    int_i = 1'b0;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); t = tag_q.pop_front(); total++;
      if (obs_q.size() == 0) $display("FAIL %s: got no sample, expected %h", t, e);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL %s: got %h expected %h", t, o, e);
        else passed++;
      end
    end
  endtask

  task automatic test_ecall;
    logic [W-1:0] e, o; string t;
    ecall_i = 1'b1;
    push_exp("ecall_take", 1, 32'h124, 4'd9, 0, 32'h44, S_HND);
    boundary(32'h40);
    ecall_i = 1'b1;
    push_exp("ecall_in_hnd", 0, 32'h124, 4'd9, 0, 32'h44, S_HND);
    boundary(32'h50);
    mret_i = 1'b1;
    push_exp("ecall_mret", 1, 32'h44, 4'd9, 0, 32'h44, S_IDLE);
    boundary(32'h60);
    en_ecall_i = 1'b0; ecall_i = 1'b1;
    push_exp("ecall_disabled", 0, 32'h44, 4'd9, 0, 32'h44, S_IDLE);
    boundary(32'h70);
    en_ecall_i = 1'b1; mret_i = 1'b1;
    push_exp("mret_in_idle", 0, 32'h44, 4'd9, 0, 32'h44, S_IDLE);
    boundary(32'h80);
    ebreak_i = 1'b1;
    push_exp("ebreak_take", 1, 32'h128, 4'd10, 0, 32'h94, S_HND);
    boundary(32'h90);
    mret_i = 1'b1;
    push_exp("ebreak_mret", 1, 32'h94, 4'd10, 0, 32'h94, S_IDLE);
    boundary(32'hA0);
    en_inter_i = 1'b0; int_i = 1'b1; int_num_i = 3'd4;
    push_exp("inter_disabled", 0, 32'h94, 4'd10, 0, 32'h94, S_IDLE);
    boundary(32'hB0);
    int_i = 1'b0; en_inter_i = 1'b1;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); t = tag_q.pop_front(); total++;
      if (obs_q.size() == 0) $display("FAIL %s: got no sample, expected %h", t, e);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL %s: got %h expected %h", t, o, e);
        else passed++;
      end
    end
  endtask

  task automatic test_nmi_nest;
    logic [W-1:0] e, o; string t;
    int_i = 1'b1; int_num_i = 3'd3;
    push_exp("nest_ext", 1, 32'h10C, 4'd3, 1, 32'h500, S_HND);
    boundary(32'h500);
    int_i = 1'b0; nmi_i = 1'b1;
    push_exp("nmi_edge_wait", 0, 32'h10C, 4'd3, 0, 32'h500, S_HND);
    step();
    sample();
    push_exp("nmi_take", 1, 32'h12C, 4'd11, 0, 32'h500, S_NMI);
    boundary(32'h300);
    int_i = 1'b1; int_num_i = 3'd7;
    push_exp("nmi_masks_int", 0, 32'h12C, 4'd11, 0, 32'h500, S_NMI);
    boundary(32'h304);
    int_i = 1'b0; mret_i = 1'b1;
    push_exp("nmi_mret", 1, 32'h300, 4'd11, 0, 32'h500, S_HND);
    boundary(32'h310);
    mret_i = 1'b1;
    push_exp("hnd_mret", 1, 32'h500, 4'd11, 0, 32'h500, S_IDLE);
    boundary(32'h320);
    nmi_i = 1'b0;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); t = tag_q.pop_front(); total++;
      if (obs_q.size() == 0) $display("FAIL %s: got no sample, expected %h", t, e);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL %s: got %h expected %h", t, o, e);
        else passed++;
      end
    end
  endtask

  task automatic test_timer;
    logic [W-1:0] e, o; string t;
    do_reset(1'b1, 32'd10);
    repeat (10) step();
    push_exp("tmr_not_yet", 0, 32'd0, 4'd0, 0, 32'd0, S_IDLE);
    boundary(32'h5F0);
    push_exp("tmr_take", 1, 32'h120, 4'd8, 0, 32'h600, S_HND);
    boundary(32'h600);
    mret_i = 1'b1;
    push_exp("tmr_mret", 1, 32'h600, 4'd8, 0, 32'h600, S_IDLE);
    boundary(32'h610);
    limit_i = 32'd0;
    for (int i = 0; i < 15; i++) begin
      push_exp("tmr_limit0", 0, 32'h600, 4'd8, 0, 32'h600, S_IDLE);
      boundary(32'h700 + 32'($urandom_range(0, 63)) * 4);
    end
    en_tmr_i = 1'b0;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); t = tag_q.pop_front(); total++;
      if (obs_q.size() == 0) $display("FAIL %s: got no sample, expected %h", t, e);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL %s: got %h expected %h", t, o, e);
        else passed++;
      end
    end
  endtask

  task automatic test_nmi_vs_int_reset;
    logic [W-1:0] e, o; string t;
    do_reset(1'b0, 32'd0);
    nmi_i = 1'b1;
    step();
    int_i = 1'b1; int_num_i = 3'd6;
    push_exp("nmi_over_int", 1, 32'h12C, 4'd11, 0, 32'd0, S_NMI);
    boundary(32'h700);
    int_i = 1'b0; nmi_i = 1'b0;
    step();
    nmi_i = 1'b1;
    step();
    push_exp("nmi_pend_in_nmi", 0, 32'h12C, 4'd11, 0, 32'd0, S_NMI);
    sample();
    rst_n_i = 1'b0;
    #1;
    push_exp("rst_async", 0, 32'd0, 4'd0, 0, 32'd0, S_IDLE);
    sample();
    nmi_i = 1'b0;
    step();
    rst_n_i = 1'b1;
    push_exp("rst_clears_pend", 0, 32'd0, 4'd0, 0, 32'd0, S_IDLE);
    boundary(32'h800);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); t = tag_q.pop_front(); total++;
      if (obs_q.size() == 0) $display("FAIL %s: got no sample, expected %h", t, e);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL %s: got %h expected %h", t, o, e);
        else passed++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_ext_int();
    test_mret_held();
    test_ecall();
    test_nmi_nest();
    test_timer();
    test_nmi_vs_int_reset();
    // final report
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
